// File: rtl/gfx_pkg.sv
// Shared types and helpers for the pixel packer: FSM states, legal pixel
// depths and the colour mask that goes with each depth.
package gfx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [5:0] BPP_1  = 6'd1;
  localparam logic [5:0] BPP_2  = 6'd2;
  localparam logic [5:0] BPP_4  = 6'd4;
  localparam logic [5:0] BPP_8  = 6'd8;
  localparam logic [5:0] BPP_16 = 6'd16;
  localparam logic [5:0] BPP_32 = 6'd32;

  // Any depth outside the legal set is handled as 32 bits per pixel.
  function automatic logic [5:0] bpp_legalize(input logic [5:0] bpp);
    case (bpp)
      BPP_1, BPP_2, BPP_4, BPP_8, BPP_16, BPP_32: return bpp;
      default:                                   return BPP_32;
    endcase
  endfunction

  // Low-bpp-bits mask applied to every incoming colour.
  function automatic logic [31:0] mask_bpp(input logic [5:0] bpp);
    case (bpp)
      BPP_1:   return 32'h0000_0001;
      BPP_2:   return 32'h0000_0003;
      BPP_4:   return 32'h0000_000F;
      BPP_8:   return 32'h0000_00FF;
      BPP_16:  return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/gfx_pack_lane.sv
// Places one masked pixel at bit offset ptr inside a memory word and
// produces the byte selects it overlaps. bpp must already be legalized.
module gfx_pack_lane
  import gfx_pkg::*;
#(
  parameter int MDW = 256
) (
  input  logic [31:0]      color,
  input  logic [5:0]       bpp,
  input  logic [8:0]       ptr,
  output logic [MDW-1:0]   data,
  output logic [MDW/8-1:0] sel
);

  logic [3:0] byte_run;

  // Sub-byte pixels touch one byte; wider pixels are byte-aligned since ptr
  // is always a multiple of bpp, so they cover bpp/8 whole bytes.
  always_comb begin
    case (bpp)
      BPP_32:  byte_run = 4'hF;
      BPP_16:  byte_run = 4'h3;
      default: byte_run = 4'h1;
    endcase
    data = {{(MDW-32){1'b0}}, color & mask_bpp(bpp)} << ptr;
    sel  = {{(MDW/8-4){1'b0}}, byte_run} << ptr[8:3];
  end

endmodule

// File: rtl/gfx_pixel_packer.sv
// Streaming pixel packer: accumulates a run of pixels into MDW-bit words
// from a starting bit offset and writes each full (or final) word out.
// Optional build macro GFX_PACKER_CNT_EN adds words_o, a wrapping count of
// completed writes since reset.
// Handshakes: a pixel transfers on a clk_i edge where pix_valid_i and
// pix_ready_o are both high; a write completes on an edge where mem_req_o and
// mem_ack_i are both high, and req/adr/dat/sel hold steady until then.
module gfx_pixel_packer
  import gfx_pkg::*;
#(
  parameter int MDW = 256,
  parameter int AW  = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [7:0]       start_mb_i,
  input  logic [5:0]       bpp_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [31:0]      pix_color_i,
  input  logic             pix_last_i,
  output logic             mem_req_o,
  input  logic             mem_ack_i,
  output logic [AW-1:0]    mem_adr_o,
  output logic [MDW-1:0]   mem_dat_o,
  output logic [MDW/8-1:0] mem_sel_o,
  output logic             busy_o
`ifdef GFX_PACKER_CNT_EN
  ,
  output logic [15:0]      words_o
`endif
);

  localparam int SW = MDW / 8;

  state_e          state_q;
  logic [MDW-1:0]  acc_q;
  logic [SW-1:0]   sel_q;
  logic [8:0]      ptr_q;
  logic            last_q;
  logic [AW-1:0]   adr_q;
  logic [5:0]      bpp_q;
  logic            ready_q;
  logic            req_q;
  logic            busy_q;

  logic [5:0]      bpp_start;
  logic [8:0]      ptr_start;
  logic [8:0]      ptr_nxt;
  logic            word_done;
  logic [MDW-1:0]  lane_dat;
  logic [SW-1:0]   lane_sel;

  // Start-time values and the pointer after the pixel currently offered.
  always_comb begin
    bpp_start = bpp_legalize(bpp_i);
    ptr_start = {1'b0, start_mb_i} & ~({3'b000, bpp_start} - 9'd1);
    ptr_nxt   = ptr_q + {3'b000, bpp_q};
    word_done = (ptr_nxt >= 9'(MDW)) || pix_last_i;
  end

  gfx_pack_lane #(.MDW(MDW)) u_lane (
    .color (pix_color_i),
    .bpp   (bpp_q),
    .ptr   (ptr_q),
    .data  (lane_dat),
    .sel   (lane_sel)
  );

  // Run control: IDLE waits for start, FILL packs pixels, WRITE holds the word until acked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      adr_q   <= '0;
      bpp_q   <= BPP_32;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            adr_q   <= addr_i;
            bpp_q   <= bpp_start;
            ptr_q   <= ptr_start;
            acc_q   <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (pix_valid_i) begin
            acc_q  <= acc_q | lane_dat;
            sel_q  <= sel_q | lane_sel;
            ptr_q  <= ptr_nxt;
            last_q <= pix_last_i;
            if (word_done) begin
              ready_q <= 1'b0;
              req_q   <= 1'b1;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (mem_ack_i) begin
            req_q <= 1'b0;
            if (last_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              adr_q   <= adr_q + AW'(SW);
              acc_q   <= '0;
              sel_q   <= '0;
              ptr_q   <= '0;
              ready_q <= 1'b1;
              state_q <= FILL;
            end
          end
        end
        default: begin
          ready_q <= 1'b0;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef GFX_PACKER_CNT_EN
  logic [15:0] words_q;

  // Count completed writes; wraps naturally at 16 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q <= '0;
    end else if (req_q && mem_ack_i) begin
      words_q <= words_q + 16'd1;
    end
  end

  assign words_o = words_q;
`endif

  assign pix_ready_o = ready_q;
  assign mem_req_o   = req_q;
  assign busy_o      = busy_q;
  assign mem_adr_o   = adr_q;
  assign mem_dat_o   = acc_q;
  assign mem_sel_o   = sel_q;

endmodule

// File: tb/tb_gfx_pixel_packer.sv
// Self-checking bench for gfx_pixel_packer (MDW=256): directed runs from the
// test plan plus randomized runs, all checked against a bit-position model.
module tb_gfx_pixel_packer;

  localparam int MDW = 256;
  localparam int AW  = 32;
  localparam int SW  = MDW / 8;

  logic             clk_i;
  logic             rst_ni;
  logic             start_i;
  logic [AW-1:0]    addr_i;
  logic [7:0]       start_mb_i;
  logic [5:0]       bpp_i;
  logic             pix_valid_i;
  logic             pix_ready_o;
  logic [31:0]      pix_color_i;
  logic             pix_last_i;
  logic             mem_req_o;
  logic             mem_ack_i;
  logic [AW-1:0]    mem_adr_o;
  logic [MDW-1:0]   mem_dat_o;
  logic [SW-1:0]    mem_sel_o;
  logic             busy_o;
`ifdef GFX_PACKER_CNT_EN
  logic [15:0]      words_o;
`endif

  gfx_pixel_packer #(.MDW(MDW), .AW(AW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .addr_i      (addr_i),
    .start_mb_i  (start_mb_i),
    .bpp_i       (bpp_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .pix_color_i (pix_color_i),
    .pix_last_i  (pix_last_i),
    .mem_req_o   (mem_req_o),
    .mem_ack_i   (mem_ack_i),
    .mem_adr_o   (mem_adr_o),
    .mem_dat_o   (mem_dat_o),
    .mem_sel_o   (mem_sel_o),
    .busy_o      (busy_o)
`ifdef GFX_PACKER_CNT_EN
    ,
    .words_o     (words_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [AW-1:0]  exp_adr_q[$];
  logic [MDW-1:0] exp_q[$];
  logic [SW-1:0]  exp_sel_q[$];
  logic [31:0]    pix_q[$];

  logic [AW-1:0]  log_adr[$];
  logic [MDW-1:0] log_dat[$];
  logic [SW-1:0]  log_sel[$];

  int  ack_mode = 0;  // 0 random, 1 held low, 2 held high
  int  exp_cnt  = 0;

  task automatic chk(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Reference model: place pixel i at absolute bit p0 + i*bpp of the run,
  // then split the run into memory words.
  task automatic model_run(input logic [31:0] addr, input logic [7:0] mb, input logic [5:0] bpp_raw);
    int b, p0, p, w, o, nw;
    logic [31:0]    m;
    logic [MDW-1:0] d[16];
    logic [SW-1:0]  s[16];
    b = (bpp_raw == 1 || bpp_raw == 2 || bpp_raw == 4 || bpp_raw == 8 ||
         bpp_raw == 16 || bpp_raw == 32) ? int'(bpp_raw) : 32;
    p0 = int'(mb) - (int'(mb) % b);
    m  = (b == 32) ? 32'hFFFF_FFFF : ((32'd1 << b) - 32'd1);
    for (int k = 0; k < 16; k++) begin
      d[k] = '0;
      s[k] = '0;
    end
    nw = 0;
    for (int i = 0; i < pix_q.size(); i++) begin
      p = p0 + i * b;
      w = p / MDW;
      o = p % MDW;
      d[w] = d[w] | ({{(MDW-32){1'b0}}, pix_q[i] & m} << o);
      for (int j = 0; j < b; j++) s[w][(o + j) / 8] = 1'b1;
      nw = w + 1;
    end
    for (int k = 0; k < nw; k++) begin
      exp_adr_q.push_back(addr + 32'(k * SW));
      exp_q.push_back(d[k]);
      exp_sel_q.push_back(s[k]);
    end
  endtask

  // ---------------- memory-side ack driver ----------------
  initial begin
    mem_ack_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ack_mode)
        1:       mem_ack_i = 1'b0;
        2:       mem_ack_i = 1'b1;
        default: mem_ack_i = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic           held;
  logic [AW-1:0]  held_adr;
  logic [MDW-1:0] held_dat;
  logic [SW-1:0]  held_sel;

  initial begin
    held = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        held    = 1'b0;
        exp_cnt = 0;
      end else begin
`ifdef GFX_PACKER_CNT_EN
        chk("words_o", MDW'(words_o), MDW'(exp_cnt[15:0]));
`endif
        if (held) begin
          chk("req_held", MDW'(mem_req_o), 1);
          chk("adr_stable", MDW'(mem_adr_o), MDW'(held_adr));
          chk("dat_stable", mem_dat_o, held_dat);
          chk("sel_stable", MDW'(mem_sel_o), MDW'(held_sel));
        end
        if (mem_req_o) begin
          chk("ready_in_write", MDW'(pix_ready_o), 0);
          chk("busy_in_write", MDW'(busy_o), 1);
        end
        if (mem_req_o && mem_ack_i) begin
          chk("write_expected", MDW'(exp_adr_q.size() != 0), 1);
          if (exp_adr_q.size() != 0) begin
            chk("wr_adr", MDW'(mem_adr_o), MDW'(exp_adr_q.pop_front()));
            chk("wr_dat", mem_dat_o, exp_q.pop_front());
            chk("wr_sel", MDW'(mem_sel_o), MDW'(exp_sel_q.pop_front()));
          end
          log_adr.push_back(mem_adr_o);
          log_dat.push_back(mem_dat_o);
          log_sel.push_back(mem_sel_o);
          exp_cnt = (exp_cnt + 1) & 32'hFFFF;
          held = 1'b0;
        end else if (mem_req_o) begin
          held     = 1'b1;
          held_adr = mem_adr_o;
          held_dat = mem_dat_o;
          held_sel = mem_sel_o;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int budget = 0;
    forever begin
      @(negedge clk_i);
      if (!busy_o) break;
      budget++;
      if (budget > 400) timeout_fail(name);
    end
  endtask

  // Drive one run using the colours in pix_q; optionally wait for its end.
  task automatic send_run(input logic [31:0] addr, input logic [7:0] mb,
                          input logic [5:0] bpp, input bit wait_done);
    int n;
    int budget;
    n = pix_q.size();
    model_run(addr, mb, bpp);
    wait_idle("idle_before_start");
    @(posedge clk_i);
    #1;
    start_i    = 1'b1;
    addr_i     = addr;
    start_mb_i = mb;
    bpp_i      = bpp;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    addr_i  = 32'hDEAD_0000;
    bpp_i   = 6'd1;
    chk("busy_after_start", MDW'(busy_o), 1);
    chk("ready_after_start", MDW'(pix_ready_o), 1);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
      pix_valid_i = 1'b1;
      pix_color_i = pix_q[i];
      pix_last_i  = (i == n - 1);
      if (i == 1) start_i = 1'b1;  // must be ignored while busy
      budget = 0;
      forever begin
        @(negedge clk_i);
        if (pix_ready_o) break;
        budget++;
        if (budget > 400) timeout_fail("pixel_accept");
      end
      @(posedge clk_i);
      #1;
      pix_valid_i = 1'b0;
      pix_last_i  = 1'b0;
      pix_color_i = $urandom;
      start_i     = 1'b0;
    end
    if (wait_done) begin
      wait_idle("run_done");
      chk("queue_drained", MDW'(exp_adr_q.size()), 0);
    end
  endtask

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
    log_sel.delete();
    pix_q.delete();
  endtask

  // ---------------- stimulus ----------------
  logic [MDW-1:0] lit;
  logic [5:0]     bpp_tab[8];
  int             budget;

  initial begin
    bpp_tab = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd3, 6'd0};
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    addr_i      = '0;
    start_mb_i  = '0;
    bpp_i       = 6'd32;
    pix_valid_i = 1'b0;
    pix_color_i = '0;
    pix_last_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", MDW'(pix_ready_o), 0);
    chk("rst_req", MDW'(mem_req_o), 0);
    chk("rst_busy", MDW'(busy_o), 0);
    chk("rst_adr", MDW'(mem_adr_o), 0);
    chk("rst_dat", mem_dat_o, 0);
    chk("rst_sel", MDW'(mem_sel_o), 0);
`ifdef GFX_PACKER_CNT_EN
    chk("rst_words", MDW'(words_o), 0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 32-bit full word
    ack_mode = 0;
    clear_log();
    for (int k = 1; k <= 8; k++) pix_q.push_back(32'h1111_1111 * k);
    send_run(32'h1000, 8'h00, 6'd32, 1'b1);
    chk("t32_nwr", MDW'(log_adr.size()), 1);
    chk("t32_adr", MDW'(log_adr[0]), 32'h1000);
    chk("t32_sel", MDW'(log_sel[0]), 32'hFFFF_FFFF);
    lit = log_dat[0];
    chk("t32_lane5", MDW'(lit[191:160]), 32'h6666_6666);

    // 16-bit short run at bit offset 0x20
    clear_log();
    pix_q = '{32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_CCCC};
    send_run(32'h3000, 8'h20, 6'd16, 1'b1);
    lit = MDW'(48'hCCCC_BBBB_AAAA) << 32;
    chk("t16_dat", log_dat[0], lit);
    chk("t16_sel", MDW'(log_sel[0]), 32'h0000_03F0);

    // 8-bit two-word run
    clear_log();
    for (int k = 0; k < 40; k++) pix_q.push_back($urandom);
    send_run(32'h2000, 8'h00, 6'd8, 1'b1);
    chk("t8_nwr", MDW'(log_adr.size()), 2);
    chk("t8_adr0", MDW'(log_adr[0]), 32'h2000);
    chk("t8_sel0", MDW'(log_sel[0]), 32'hFFFF_FFFF);
    chk("t8_adr1", MDW'(log_adr[1]), 32'h2020);
    chk("t8_sel1", MDW'(log_sel[1]), 32'h0000_00FF);

    // colour masking
    clear_log();
    pix_q = '{32'hABCD_EF12};
    send_run(32'h4000, 8'h00, 6'd8, 1'b1);
    chk("mask_dat", log_dat[0], MDW'(8'h12));
    chk("mask_sel", MDW'(log_sel[0]), 32'h1);

    // illegal depth handled as 32 bits, offset rounded down to 0x20
    clear_log();
    pix_q = '{32'hDEAD_BEEF};
    send_run(32'h5000, 8'h21, 6'd3, 1'b1);
    lit = MDW'(32'hDEAD_BEEF) << 32;
    chk("ill_dat", log_dat[0], lit);
    chk("ill_sel", MDW'(log_sel[0]), 32'h0000_00F0);

    // backpressure: ack low for 5 cycles
    clear_log();
    ack_mode = 1;
    pix_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    send_run(32'h6000, 8'h08, 6'd8, 1'b0);
    budget = 0;
    while (!mem_req_o) begin
      @(negedge clk_i);
      budget++;
      if (budget > 50) timeout_fail("bp_req");
    end
    repeat (5) begin
      @(negedge clk_i);
      chk("bp_req", MDW'(mem_req_o), 1);
      chk("bp_ready", MDW'(pix_ready_o), 0);
    end
    ack_mode = 2;
    wait_idle("bp_done");
    chk("bp_nwr", MDW'(log_adr.size()), 1);
    chk("bp_sel", MDW'(log_sel[0]), 32'h0000_001E);
    ack_mode = 0;

    // reset while a write is pending
    ack_mode = 1;
    pix_q = '{32'h5, 32'h6};
    send_run(32'h7000, 8'h00, 6'd16, 1'b0);
    budget = 0;
    while (!mem_req_o) begin
      @(negedge clk_i);
      budget++;
      if (budget > 50) timeout_fail("rst_req_wait");
    end
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_req", MDW'(mem_req_o), 0);
    chk("mid_rst_busy", MDW'(busy_o), 0);
    chk("mid_rst_ready", MDW'(pix_ready_o), 0);
    chk("mid_rst_dat", mem_dat_o, 0);
    exp_adr_q.delete();
    exp_q.delete();
    exp_sel_q.delete();
    ack_mode = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_log();
    pix_q = '{32'h1234_5678};
    send_run(32'h8000, 8'h40, 6'd32, 1'b1);
    chk("post_rst_adr", MDW'(log_adr[0]), 32'h8000);
    chk("post_rst_sel", MDW'(log_sel[0]), 32'h0000_0F00);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      clear_log();
      ack_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      for (int k = $urandom_range(1, 80); k > 0; k--) pix_q.push_back($urandom);
      send_run($urandom & 32'hFFFF_FFE0, 8'($urandom_range(0, 255)),
               bpp_tab[$urandom_range(0, 7)], 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
